// File: rtl/dut_port_arbiter.sv
// Round-robin arbiter/sequencer sharing a single-port wr/rd resource among
// NUM_REQ requesters; one outstanding transaction, fixed read latency.
module dut_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        res_wr,
  output logic                        res_rd,
  output logic [DATA_W-1:0]           res_din,
  input  logic [DATA_W-1:0]           res_dout,
  input  logic                        res_busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0]   win, win_n;
  logic               rw_q, rw_n;
  logic [LAT_W-1:0]   lat_cnt, lat_n;
  logic [DATA_W-1:0]  cap, cap_n;

  logic [NUM_REQ-1:0] req_ready_n, rsp_valid_n;
  logic [DATA_W-1:0]  rsp_rdata_n, res_din_n;
  logic               res_wr_n, res_rd_n;

  logic [IDX_W-1:0]   arb_idx;
  logic               arb_hit;
  int unsigned        pos;

  // Rotating priority search starting at rr_ptr; first valid requester wins.
  always_comb begin
    arb_idx = '0;
    arb_hit = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!arb_hit && req_valid[IDX_W'(pos)]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'(pos);
      end
    end
  end

  // Next-state and next-output logic; outputs are registered on entry to each state.
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    win_n       = win;
    rw_n        = rw_q;
    lat_n       = lat_cnt;
    cap_n       = cap;
    req_ready_n = '0;
    rsp_valid_n = '0;
    rsp_rdata_n = '0;
    res_wr_n    = 1'b0;
    res_rd_n    = 1'b0;
    res_din_n   = '0;

    case (state)
      IDLE: begin
        if (arb_hit && !res_busy) begin
          win_n                = arb_idx;
          rw_n                 = req_rw[arb_idx];
          req_ready_n[arb_idx] = 1'b1;
          state_n              = ISSUE;
          if (req_rw[arb_idx]) begin
            res_wr_n  = 1'b1;
            res_din_n = req_wdata[32'(arb_idx)*DATA_W +: DATA_W];
          end else begin
            res_rd_n  = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (32'(win) == NUM_REQ - 1) rr_ptr_n = '0;
        else                         rr_ptr_n = win + IDX_W'(1);
        if (rw_q) begin
          state_n = IDLE;
        end else begin
          state_n = WAIT;
          lat_n   = LAT_W'(RD_LAT);
        end
      end

      WAIT: begin
        lat_n = lat_cnt - LAT_W'(1);
        if (lat_cnt == LAT_W'(1)) begin
          cap_n            = res_dout;
          rsp_rdata_n      = res_dout;
          rsp_valid_n[win] = 1'b1;
          state_n          = RESP;
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // State, context and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win       <= '0;
      rw_q      <= 1'b0;
      lat_cnt   <= '0;
      cap       <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      res_wr    <= 1'b0;
      res_rd    <= 1'b0;
      res_din   <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      win       <= win_n;
      rw_q      <= rw_n;
      lat_cnt   <= lat_n;
      cap       <= cap_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      res_wr    <= res_wr_n;
      res_rd    <= res_rd_n;
      res_din   <= res_din_n;
    end
  end

  // Structural invariants of the resource interface.
  a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(res_wr && res_rd));
  a_ready_oh:    assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_oh:      assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_no_strobe:   assert property (@(posedge clk) disable iff (rst)
                   (state == WAIT || state == RESP) |-> !(res_wr || res_rd));

endmodule

// File: doc/dut_port_arbiter.md
Name: dut_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single-port 8-bit wr/rd datapath of the DUT-style resource (wr, rd, in, out, busy flag x) among NUM_REQ independent requesters.
- Accepts one write or read transaction at a time and drives the resource's wr/rd strobes and write data.
- Waits the fixed read latency, then returns read data to the requester that issued the read.
- Sits between the requester agents and the resource. The same checker modules bind to the resource unchanged.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width of resource in/out
RD_LAT, 1, cycles from res_rd strobe to valid res_dout (1..15)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester transaction request, held until req_ready
req_rw  input  NUM_REQ  per-requester 1=write, 0=read; stable while req_valid
req_wdata  input  NUM_REQ*DATA_W  per-requester write data, requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot accept pulse
rsp_valid  output  NUM_REQ  one-hot read-response pulse
rsp_rdata  output  DATA_W  read data, valid when any rsp_valid bit is set
res_wr  output  1  resource write strobe
res_rd  output  1  resource read strobe
res_din  output  DATA_W  data to resource input port
res_dout  input  DATA_W  resource output port
res_busy  input  1  resource busy flag (x); blocks new issue

Behaviour:
- Reset: all outputs and registers reset to 0, with state=IDLE, rr_ptr=0, lat_cnt=0 and the captured-data register cleared.
- Reset mid-transaction: an in-flight read is dropped and no rsp_valid is produced. The next grant is priority-ordered from requester 0.
- FSM states: IDLE, ISSUE, WAIT, RESP. Only one transaction is outstanding at any time.
- IDLE:
  - Arbitration happens when any req_valid=1 and res_busy=0 in cycle T.
  - Winner = first set req_valid bit searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - Register the winner index, rw and wdata, then go to ISSUE.
  - res_busy=1 blocks arbitration. res_busy is sampled in IDLE only and is ignored once a transaction has been issued.
- ISSUE (cycle T+1, exactly one cycle):
  - req_ready[winner]=1.
  - Write: res_wr=1 and res_din=captured wdata.
  - Read: res_rd=1 and res_din=0.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Next state: write -> IDLE; read -> WAIT with lat_cnt loaded to RD_LAT.
- WAIT:
  - lat_cnt decrements each cycle.
  - When lat_cnt==1, capture res_dout (valid in cycle T+1+RD_LAT) and go to RESP.
- RESP (cycle T+2+RD_LAT, one cycle):
  - rsp_valid[winner]=1 and rsp_rdata=captured data.
  - Next state: IDLE.
- Throughput:
  - Back-to-back writes issue every 2 cycles.
  - Back-to-back reads issue every RD_LAT+3 cycles.
- Output defaults:
  - res_wr, res_rd, req_ready and rsp_valid are 0 outside their states.
  - res_din and rsp_rdata are 0 when not strobed.
  - All outputs are registered.
- Requester rules:
  - A requester keeps req_valid, req_rw and req_wdata stable until req_ready.
  - A requester may drop req_valid without being granted. It is only considered if valid in the arbitration cycle.
- Invariants:
  - res_wr and res_rd are never both high.
  - req_ready and rsp_valid are each at most one-hot.
  - No new strobe is issued while in WAIT or RESP.
- rr_ptr advances only on a grant. It wraps from NUM_REQ-1 to 0.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with all req_valid=1 -> all outputs 0 throughout. The first issue goes to requester 0 two cycles after rst falls.
2. Single write: req 2 valid, rw=1, wdata=0xA5 at T -> T+1 res_wr=1, res_din=0xA5, req_ready=4'b0100. T+2 all strobes 0.
3. Single read with RD_LAT=1: req 1 read at T, res_dout=0x3C in T+2 -> T+1 res_rd=1, req_ready=4'b0010. T+3 rsp_valid=4'b0010, rsp_rdata=0x3C.
4. Fairness: all four requesters issue continuous writes with wdata=0x10+i -> grants 0,1,2,3,0 on cycles T+1, T+3, T+5, T+7, T+9 with matching res_din.
5. Busy stall: req 0 valid while res_busy=1 for 5 cycles -> no res_wr/res_rd during the stall. Issue occurs 2 cycles after res_busy falls. Raising res_busy during WAIT does not block the pending rsp_valid.
6. Reset mid-read: assert rst during WAIT with RD_LAT=3 -> rsp_valid never asserts. After reset, req 3 and req 0 both valid -> req 0 is granted first.
